// File: rtl/rvcpu_clk_pkg.sv
// Shared types and constants for the CPU run/halt/step clock-enable controller.
package rvcpu_clk_pkg;

  // Controller state; the encoding doubles as the externally visible mode.
  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } step_state_t;

  localparam logic [1:0] MODE_HALT = ST_HALT;
  localparam logic [1:0] MODE_RUN  = ST_RUN;
  localparam logic [1:0] MODE_STEP = ST_STEP;

  localparam logic [31:0] DIV_DEFAULT_C      = 32'd100_000_000;
  localparam logic [31:0] DEBOUNCE_DEFAULT_C = 32'd1_000_000;

  // A zero divisor would never reach terminal count, so treat it as 1.
  function automatic logic [31:0] div_effective(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_input_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw input.
module input_debouncer
  import rvcpu_clk_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT_C
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic db_out
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        db_q, db_d;
  logic [31:0] db_cnt_q, db_cnt_d;

  // Next-state: count consecutive cycles where the synchronized input disagrees
  // with the accepted level; any agreeing cycle restarts the count.
  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == db_q) begin
      db_cnt_d = 32'd0;
    end else if (db_cnt_q == DEBOUNCE_CYCLES - 32'd1) begin
      db_d     = sync2_q;
      db_cnt_d = 32'd0;
    end else begin
      db_cnt_d = db_cnt_q + 32'd1;
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_cnt_q <= 32'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign db_out = db_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/halt/single-step controller: issues one-cycle clock-enable pulses to the
// CPU core, either periodically (RUN) or once per step button press (STEP).
module cpu_step_ctrl
  import rvcpu_clk_pkg::*;
#(
  parameter logic [31:0] DIV_DEFAULT     = DIV_DEFAULT_C,
  parameter logic [31:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  input  logic        div_wr,
  input  logic [31:0] div_data,
  output logic        cpu_en,
  output logic [1:0]  mode,
  output logic [31:0] tick_count
);

  logic        run_db;
  logic        step_db;
  logic        step_db_q, step_db_d;
  logic        step_evt;

  step_state_t state_q, state_d;
  logic        cpu_en_q, cpu_en_d;
  logic [31:0] tick_count_q, tick_count_d;
  logic [31:0] div_q, div_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        halt_lat_q, halt_lat_d;
  logic [31:0] div_eff;
  logic        run_tc;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk    (clk),
    .rst    (rst),
    .raw_in (run_sw),
    .db_out (run_db)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk    (clk),
    .rst    (rst),
    .raw_in (step_btn),
    .db_out (step_db)
  );

  assign step_evt = step_db & ~step_db_q;
  assign div_eff  = div_effective(div_q);
  assign run_tc   = (run_cnt_q == div_eff - 32'd1);

  // FSM next-state plus divisor, run counter, halt latch and tick counter updates.
  always_comb begin
    state_d      = state_q;
    cpu_en_d     = 1'b0;
    run_cnt_d    = run_cnt_q;
    halt_lat_d   = halt_lat_q;
    div_d        = div_q;
    step_db_d    = step_db;
    tick_count_d = tick_count_q + {31'd0, cpu_en_q};

    case (state_q)
      ST_HALT: begin
        if (run_db && !halt_lat_q) begin
          state_d   = ST_RUN;
          run_cnt_d = 32'd0;
        end else if (step_evt) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d    = ST_HALT;
          halt_lat_d = 1'b1;
        end else if (!run_db) begin
          state_d = ST_HALT;
        end else if (run_tc) begin
          // A divisor write in the same cycle restarts the period instead.
          cpu_en_d  = !div_wr;
          run_cnt_d = 32'd0;
        end else begin
          run_cnt_d = run_cnt_q + 32'd1;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
        if (halt_req) halt_lat_d = 1'b1;
      end
      default: state_d = ST_HALT;
    endcase

    if (div_wr) begin
      div_d     = div_data;
      run_cnt_d = 32'd0;
    end

    // Switching run off re-arms RUN after a core-requested halt.
    if (!run_db) halt_lat_d = 1'b0;
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HALT;
      cpu_en_q     <= 1'b0;
      tick_count_q <= 32'd0;
      div_q        <= DIV_DEFAULT;
      run_cnt_q    <= 32'd0;
      halt_lat_q   <= 1'b0;
      step_db_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_en_q     <= cpu_en_d;
      tick_count_q <= tick_count_d;
      div_q        <= div_d;
      run_cnt_q    <= run_cnt_d;
      halt_lat_q   <= halt_lat_d;
      step_db_q    <= step_db_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign mode       = state_q;
  assign tick_count = tick_count_q;

endmodule
